// File: rtl/ps2_rx_buffered_if.sv
// Read-side bus of the buffered PS/2 receiver: first-word fall-through FIFO head plus occupancy.
// Handshake: a word transfers on a clk edge where rd_valid=1 and rd_en=1; rd_en with rd_valid=0 is ignored.
interface ps2_rx_buffered_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) ();
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic [CW-1:0]        fifo_count;

  modport master (
    input  rd_en,
    output rd_data,
    output rd_valid,
    output fifo_count
  );

  modport slave (
    output rd_en,
    input  rd_data,
    input  rd_valid,
    input  fifo_count
  );
endinterface

// File: rtl/ps2_rx_buffered.sv
// PS/2 frame receiver (start, data LSB-first, odd parity, stop) feeding a small FWFT word FIFO.
// Bad frames, stalled frames and words that find the FIFO full are dropped with a one-cycle pulse.
module ps2_rx_buffered #(
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wait_for_incoming_data,
  input  logic       start_receiving_data,
  input  logic       ps2_clk_posedge,
  input  logic       ps2_clk_negedge,
  input  logic       ps2_data,
  ps2_rx_buffered_if.master rd_bus,
  output logic       parity_error,
  output logic       frame_error,
  output logic       timeout_error,
  output logic       overflow,
  output logic [2:0] state_dbg
);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_FOR_DATA = 3'd1,
    DATA_IN       = 3'd2,
    PARITY_IN     = 3'd3,
    STOP_IN       = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [BCW-1:0]       bit_cnt;
  logic [TCW-1:0]       tmo_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;

  logic                 in_frame;
  logic                 timeout_hit;
  logic                 stop_strobe;
  logic                 parity_ok;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;

  // The falling-edge strobe carries no information for a receiver sampling on rising edges.
  logic unused_negedge;
  assign unused_negedge = ps2_clk_negedge;

  assign in_frame    = (state_q == DATA_IN) || (state_q == PARITY_IN) || (state_q == STOP_IN);
  // A strobe on the deadline cycle rescues the frame.
  assign timeout_hit = in_frame && !ps2_clk_posedge && (tmo_cnt == TCW'(TIMEOUT_CYCLES - 1));
  assign stop_strobe = (state_q == STOP_IN) && ps2_clk_posedge;
  assign parity_ok   = (^shift_reg) ^ parity_bit;

  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign pop       = rd_bus.rd_en && rd_bus.rd_valid;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push      = stop_strobe && parity_ok && ps2_data && (!fifo_full || rd_bus.rd_en);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wait_for_incoming_data)    state_d = WAIT_FOR_DATA;
        else if (start_receiving_data) state_d = DATA_IN;
      end
      WAIT_FOR_DATA: begin
        if (ps2_clk_posedge && !ps2_data) state_d = DATA_IN;
        else if (!wait_for_incoming_data) state_d = IDLE;
      end
      DATA_IN: begin
        if (timeout_hit) state_d = IDLE;
        else if (ps2_clk_posedge && (bit_cnt == BCW'(DATA_BITS - 1))) state_d = PARITY_IN;
      end
      PARITY_IN: begin
        if (timeout_hit)          state_d = IDLE;
        else if (ps2_clk_posedge) state_d = STOP_IN;
      end
      STOP_IN: begin
        if (timeout_hit || ps2_clk_posedge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt       <= '0;
      tmo_cnt       <= '0;
      shift_reg     <= '0;
      parity_bit    <= 1'b0;
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
      timeout_error <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (state_q != DATA_IN)   bit_cnt <= '0;
      else if (ps2_clk_posedge) bit_cnt <= bit_cnt + 1'b1;

      if ((state_q == DATA_IN) && ps2_clk_posedge)
        shift_reg <= (shift_reg >> 1) | (DATA_BITS'(ps2_data) << (DATA_BITS - 1));

      if ((state_q == PARITY_IN) && ps2_clk_posedge)
        parity_bit <= ps2_data;

      if (!in_frame || ps2_clk_posedge || timeout_hit) tmo_cnt <= '0;
      else                                             tmo_cnt <= tmo_cnt + 1'b1;

      // Exactly one outcome per stop strobe, parity checked first.
      parity_error  <= stop_strobe && !parity_ok;
      frame_error   <= stop_strobe && parity_ok && !ps2_data;
      overflow      <= stop_strobe && parity_ok && ps2_data && fifo_full && !rd_bus.rd_en;
      timeout_error <= timeout_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rd_bus.rd_valid   = (count != '0);
  assign rd_bus.rd_data    = rd_bus.rd_valid ? mem[rd_ptr] : '0;
  assign rd_bus.fifo_count = count;
endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Directed bench for ps2_rx_buffered: frames are driven strobe by strobe, expected words
// are queued when a frame is sent and compared when they are popped from the FIFO.
module tb_ps2_rx_buffered;
  localparam int DATA_BITS = 8;
  localparam int DEPTH     = 4;
  localparam int TMO       = 100;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic       clk = 1'b0;
  logic       reset;
  logic       wait_for_incoming_data;
  logic       start_receiving_data;
  logic       ps2_clk_posedge;
  logic       ps2_clk_negedge;
  logic       ps2_data;
  logic       parity_error, frame_error, timeout_error, overflow;
  logic [2:0] state_dbg;

  ps2_rx_buffered_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(DEPTH)) rd_bus ();

  ps2_rx_buffered #(
    .DATA_BITS(DATA_BITS), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wait_for_incoming_data(wait_for_incoming_data),
    .start_receiving_data(start_receiving_data),
    .ps2_clk_posedge(ps2_clk_posedge),
    .ps2_clk_negedge(ps2_clk_negedge),
    .ps2_data(ps2_data),
    .rd_bus(rd_bus.master),
    .parity_error(parity_error),
    .frame_error(frame_error),
    .timeout_error(timeout_error),
    .overflow(overflow),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [DATA_BITS-1:0] exp_q[$];
  int model_count = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pulses(input string tag, input logic p, input logic f,
                              input logic t, input logic o);
    check({tag, "_pulses"}, {28'd0, parity_error, frame_error, timeout_error, overflow},
          {28'd0, p, f, t, o});
  endtask

  // driver tasks
  task automatic strobe(input logic b, input logic with_pop);
    @(negedge clk);
    ps2_clk_negedge = 1'($urandom_range(0, 1));
    @(negedge clk);
    ps2_clk_negedge = 1'b0;
    ps2_data        = b;
    ps2_clk_posedge = 1'b1;
    rd_bus.rd_en    = with_pop;
    @(negedge clk);
    ps2_clk_posedge = 1'b0;
    rd_bus.rd_en    = 1'b0;
    ps2_data        = 1'b1;
  endtask

  task automatic send_frame(input string tag, input logic [DATA_BITS-1:0] d,
                            input logic par_bad, input logic stop_val, input logic pop_on_stop);
    logic par, good, exp_ovf, exp_push;
    par = ~(^d);
    if (par_bad) par = ~par;
    good     = !par_bad && stop_val;
    exp_ovf  = good && (model_count == DEPTH) && !pop_on_stop;
    exp_push = good && !exp_ovf;
    strobe(1'b0, 1'b0);
    for (int i = 0; i < DATA_BITS; i++) strobe(d[i], 1'b0);
    strobe(par, 1'b0);
    if (pop_on_stop) begin
      check({tag, "_head_before_pop"}, rd_bus.rd_data, exp_q.pop_front());
      model_count--;
    end
    strobe(stop_val, pop_on_stop);
    if (exp_push) begin
      exp_q.push_back(d);
      model_count++;
    end
    check_pulses(tag, par_bad, !par_bad && !stop_val, 1'b0, exp_ovf);
    check({tag, "_count"}, rd_bus.fifo_count, model_count);
    check({tag, "_valid"}, rd_bus.rd_valid, model_count != 0);
    if (model_count != 0) check({tag, "_head"}, rd_bus.rd_data, exp_q[0]);
    @(negedge clk);
    check_pulses({tag, "_after"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic read_word(input string tag);
    logic [DATA_BITS-1:0] e;
    @(negedge clk);
    check({tag, "_valid"}, rd_bus.rd_valid, 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({tag, "_data"}, rd_bus.rd_data, e);
    rd_bus.rd_en = 1'b1;
    @(negedge clk);
    rd_bus.rd_en = 1'b0;
    if (model_count > 0) model_count--;
    check({tag, "_count"}, rd_bus.fifo_count, model_count);
  endtask

  initial begin
    reset = 1'b0;
    wait_for_incoming_data = 1'b0;
    start_receiving_data   = 1'b0;
    ps2_clk_posedge = 1'b0;
    ps2_clk_negedge = 1'b0;
    ps2_data        = 1'b1;
    rd_bus.rd_en    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_count", rd_bus.fifo_count, 0);
    check("rst_valid", rd_bus.rd_valid, 0);
    check("rst_data", rd_bus.rd_data, 0);
    check_pulses("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    wait_for_incoming_data = 1'b1;

    // basic good frame, then empty-read is ignored
    send_frame("f5a", 8'h5A, 1'b0, 1'b1, 1'b0);
    read_word("rd5a");
    @(negedge clk);
    rd_bus.rd_en = 1'b1;
    @(negedge clk);
    rd_bus.rd_en = 1'b0;
    check("empty_rd_count", rd_bus.fifo_count, 0);
    check("empty_rd_valid", rd_bus.rd_valid, 0);

    // parity and stop errors
    send_frame("par_bad", 8'h5A, 1'b1, 1'b1, 1'b0);
    send_frame("stop_bad", 8'h5A, 1'b0, 1'b0, 1'b0);

    // fill past depth
    for (int i = 1; i <= 5; i++) send_frame($sformatf("fill%0d", i), 8'(i), 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) read_word($sformatf("drain%0d", i));

    // timeout after start + 3 data bits
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (k == TMO - 1) check("tmo_early", timeout_error, 0);
    end
    check("tmo_pulse", timeout_error, 1);
    check("tmo_state", state_dbg, ST_IDLE);
    check("tmo_count", rd_bus.fifo_count, model_count);
    @(negedge clk);
    check("tmo_clear", timeout_error, 0);
    send_frame("fa5", 8'hA5, 1'b0, 1'b1, 1'b0);
    read_word("rda5");

    // push and pop on the same edge while full
    for (int i = 0; i < DEPTH; i++)
      send_frame($sformatf("pre%0d", i), 8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0);
    send_frame("f77", 8'h77, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) read_word($sformatf("post%0d", i));

    // reset mid-frame with two words buffered
    send_frame("b0", 8'h11, 1'b0, 1'b1, 1'b0);
    send_frame("b1", 8'h22, 1'b0, 1'b1, 1'b0);
    strobe(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) strobe(1'(i & 1), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_count", rd_bus.fifo_count, 0);
    check("mid_rst_valid", rd_bus.rd_valid, 0);
    check("mid_rst_state", state_dbg, ST_IDLE);
    check_pulses("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    model_count = 0;
    send_frame("f3c", 8'h3C, 1'b0, 1'b1, 1'b0);
    read_word("rd3c");
    check("f3c_sole", rd_bus.rd_valid, 0);

    // random frames with occasional bad parity and random reads
    for (int n = 0; n < 8; n++) begin
      send_frame($sformatf("rnd%0d", n), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) == 0), 1'b1, 1'b0);
      if ((model_count != 0) && ($urandom_range(0, 2) == 0)) read_word($sformatf("rrd%0d", n));
    end
    while (model_count > 0) read_word("rnd_drain");
    check("final_valid", rd_bus.rd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_rx_buffered.md
PS2_RX_BUFFERED -- requirements
Module: ps2_rx_buffered

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per PS/2 frame.
REQ-002 Parameter FIFO_DEPTH, default 4, received-word buffer depth; power of 2, >=2.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, clk cycles allowed between ps2_clk_posedge pulses inside a frame; >=2.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 wait_for_incoming_data  in  1  arm receiver to hunt for a start bit.
REQ-007 start_receiving_data  in  1  start bit already consumed externally; begin directly at data bits.
REQ-008 ps2_clk_posedge  in  1  one-clk pulse per PS/2 clock rising edge; the sampling strobe.
REQ-009 ps2_clk_negedge  in  1  one-clk pulse per PS/2 clock falling edge; ignored, kept for port compatibility.
REQ-010 ps2_data  in  1  synchronised PS/2 data line.
REQ-011 rd_en  in  1  pop head word when rd_valid=1.
REQ-012 rd_data  out  DATA_BITS  FIFO head word (first-word fall-through).
REQ-013 rd_valid  out  1  FIFO non-empty.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH+1)  words held.
REQ-015 parity_error  out  1  one-cycle pulse: frame dropped, bad odd parity.
REQ-016 frame_error  out  1  one-cycle pulse: frame dropped, stop bit 0.
REQ-017 timeout_error  out  1  one-cycle pulse: frame aborted, no strobe within TIMEOUT_CYCLES.
REQ-018 overflow  out  1  one-cycle pulse: good frame dropped, FIFO full.

Function
REQ-019 States SHALL be IDLE, WAIT_FOR_DATA, DATA_IN, PARITY_IN, STOP_IN; default/illegal -> IDLE.
REQ-020 IDLE: wait_for_incoming_data=1 -> WAIT_FOR_DATA; else start_receiving_data=1 -> DATA_IN; wait has priority.
REQ-021 WAIT_FOR_DATA: strobe with ps2_data=0 -> DATA_IN; else wait_for_incoming_data=0 -> IDLE; else hold.
REQ-022 DATA_IN: each strobe shifts ps2_data in LSB-first and increments bit counter; strobe on bit DATA_BITS-1 -> PARITY_IN; counter clears outside DATA_IN.
REQ-023 PARITY_IN: strobe samples parity bit -> STOP_IN; parity good when XOR(data bits, parity bit)=1.
REQ-024 STOP_IN: strobe samples stop bit -> IDLE; on that same edge exactly one outcome, priority: parity bad -> parity_error; else stop=0 -> frame_error; else FIFO full and rd_en=0 -> overflow; else word pushed.
REQ-025 Outcome pulses and pushed word SHALL be visible the cycle after the stop-bit strobe (rd_valid latency 1 cycle from that strobe).
REQ-026 Timeout counter SHALL run only in DATA_IN/PARITY_IN/STOP_IN, clear on every strobe and on entry; strobe-free cycle with count=TIMEOUT_CYCLES-1 -> IDLE, timeout_error pulse, partial frame discarded, FIFO untouched.
REQ-027 Strobe and timeout on same cycle: strobe wins, no timeout.
REQ-028 FIFO: rd_en with rd_valid=0 ignored; push+pop same cycle -> fifo_count unchanged, legal when full; pointers wrap modulo FIFO_DEPTH; order preserved.
REQ-029 rd_data SHALL be don't-care when rd_valid=0; stable while rd_valid=1 and rd_en=0.
REQ-030 Receiver SHALL accept frames regardless of FIFO occupancy; full affects only push/overflow.

Reset
REQ-031 reset=0 at any clk edge, including mid-frame: state IDLE, bit/timeout counters 0, shift register 0, FIFO empty, rd_data 0, rd_valid 0, fifo_count 0, all error pulses 0; partial frame discarded.
REQ-032 Reset SHALL take precedence over every other input on the same edge.

Verification
REQ-033 Defaults; wait_for_incoming_data=1; frame start 0, data 0x5A LSB-first, parity 1, stop 1 -> cycle after stop strobe rd_valid=1, rd_data=0x5A, fifo_count=1, no error pulse.
REQ-034 Same frame, parity 0 -> parity_error one cycle, fifo_count 0; same frame, parity 1, stop 0 -> frame_error one cycle, fifo_count 0.
REQ-035 FIFO_DEPTH=4, frames 0x01..0x05, rd_en=0 -> overflow pulse on 5th only, fifo_count=4; four pops return 0x01,0x02,0x03,0x04; fifo_count then 0.
REQ-036 TIMEOUT_CYCLES=100; start + 3 data bits, no further strobes -> timeout_error pulse 100 cycles after last strobe, state IDLE, fifo_count unchanged; next full frame 0xA5 received correctly.
REQ-037 Full FIFO (4 words), rd_en=1 on stop-strobe cycle of 0x77 frame -> no overflow, fifo_count stays 4, 0x77 read last.
REQ-038 reset=0 after 5 data bits of a frame with 2 words buffered -> next cycle fifo_count=0, rd_valid=0, no pulses; following 0x3C frame received as sole word.
